hazard_detection_unit: RTL and testbench

//   Stall/flush controller: counterpart of the ALU forwarding logic. Handles the hazards that bypass

---
 rtl/hazard_detection_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_detection_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the ID stage. It covers the hazards that forwarding cannot
// resolve: load-use, a taken branch and a multi-cycle data memory. It drives the
// hold/flush/bubble controls of PC, IF_ID, ID_EX and EX_MEM, and it keeps a saturating
// count of the cycles in which the PC is held.
module hazard_detection_unit #(
    parameter int unsigned REG_ADDR_W     = 6,
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned MEM_TIMEOUT    = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] IF_ID_src1,
    input  logic [REG_ADDR_W-1:0] IF_ID_src2,
    input  logic                  IF_ID_src1_used,
    input  logic                  IF_ID_src2_used,
    input  logic [REG_ADDR_W-1:0] ID_EX_RD,
    input  logic                  ID_EX_memRead,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    output logic                  PC_hold,
    output logic                  IF_ID_hold,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_bubble,
    output logic                  ID_EX_hold,
    output logic                  EX_MEM_hold,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StFlush   = 2'd1;
    localparam logic [1:0] StMemWait = 2'd2;

    localparam int unsigned FlushW = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
    localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT + 1);

    localparam logic [FlushW-1:0] FlushReload = FlushW'(BRANCH_PENALTY - 1);
    localparam logic [WaitW-1:0]  WaitMax     = WaitW'(MEM_TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [1:0]        ret_state_q, ret_state_d;
    logic [1:0]        eff_state;
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q;
    logic              load_use;

    assign load_use = ID_EX_memRead &
                      ((IF_ID_src1_used & (IF_ID_src1 == ID_EX_RD)) |
                       (IF_ID_src2_used & (IF_ID_src2 == ID_EX_RD)));

    // Once the memory is ready again, act as the state the wait was entered from.
    assign eff_state = ((state_q == StMemWait) && !mem_busy) ? ret_state_q : state_q;

    // Mealy controls and next-state; priority is mem_busy > branch > flush > load-use.
    always_comb begin
        PC_hold      = 1'b0;
        IF_ID_hold   = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        ID_EX_hold   = 1'b0;
        EX_MEM_hold  = 1'b0;
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        flush_cnt_d  = flush_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        if (rst_n) begin
            if (mem_busy) begin
                // Full freeze; any pending flush count stays put until memory is ready.
                PC_hold     = 1'b1;
                IF_ID_hold  = 1'b1;
                ID_EX_hold  = 1'b1;
                EX_MEM_hold = 1'b1;
                if (state_q != StMemWait) begin
                    ret_state_d = state_q;
                    state_d     = StMemWait;
                    wait_cnt_d  = WaitW'(1);
                end else if (wait_cnt_q != WaitMax) begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
                if (wait_cnt_d == WaitMax) begin
                    timeout_d = 1'b1;
                end
            end else begin
                wait_cnt_d = '0;
                state_d    = eff_state;
                if (branch_taken) begin
                    IF_ID_flush  = 1'b1;
                    ID_EX_bubble = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_d     = StFlush;
                        flush_cnt_d = FlushReload;
                    end else begin
                        state_d = StRun;
                    end
                end else if (eff_state == StFlush) begin
                    // ID holds a squashed slot, so load-use is not looked at here.
                    IF_ID_flush = 1'b1;
                    flush_cnt_d = flush_cnt_q - FlushW'(1);
                    if (flush_cnt_q == FlushW'(1)) begin
                        state_d = StRun;
                    end
                end else if (load_use) begin
                    // One bubble suffices: next cycle EX holds a NOP, so no re-detect.
                    PC_hold      = 1'b1;
                    IF_ID_hold   = 1'b1;
                    ID_EX_bubble = 1'b1;
                end
            end
        end
    end

    // State, counters and sticky timeout; synchronous active-low reset aborts any pending work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            ret_state_q <= StRun;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            if (PC_hold && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: directed scenarios followed by random stimulus, all
// checked against a cycle model built from the priority rules with plain integers.
module tb_hazard_detection_unit;

    localparam int unsigned AW  = 6;
    localparam int unsigned BP  = 3;
    localparam int unsigned MT  = 64;
    localparam int unsigned CW  = 8;
    localparam int          STALL_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] src1, src2, rd;
    logic          src1_used, src2_used, mem_read, branch_taken, mem_busy;
    logic          pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_hold;
    logic          mem_timeout;
    logic [CW-1:0] stall_cycles;

    hazard_detection_unit #(
        .REG_ADDR_W    (AW),
        .BRANCH_PENALTY(BP),
        .MEM_TIMEOUT   (MT),
        .CNT_W         (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IF_ID_src1     (src1),
        .IF_ID_src2     (src2),
        .IF_ID_src1_used(src1_used),
        .IF_ID_src2_used(src2_used),
        .ID_EX_RD       (rd),
        .ID_EX_memRead  (mem_read),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .PC_hold        (pc_hold),
        .IF_ID_hold     (ifid_hold),
        .IF_ID_flush    (ifid_flush),
        .ID_EX_bubble   (idex_bubble),
        .ID_EX_hold     (idex_hold),
        .EX_MEM_hold    (exmem_hold),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: flush cycles still owed, consecutive busy cycles, sticky timeout, stall count.
    int m_flush_left;
    int m_busy_run;
    bit m_timeout;
    int m_stall;
    bit e_pc_hold, e_ifid_hold, e_ifid_flush, e_idex_bubble, e_idex_hold, e_exmem_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit lu;
        lu = mem_read && ((src1_used && src1 == rd) || (src2_used && src2 == rd));
        e_pc_hold = 0; e_ifid_hold = 0; e_ifid_flush = 0;
        e_idex_bubble = 0; e_idex_hold = 0; e_exmem_hold = 0;
        if (rst_n) begin
            if (mem_busy) begin
                e_pc_hold = 1; e_ifid_hold = 1; e_idex_hold = 1; e_exmem_hold = 1;
            end else if (branch_taken) begin
                e_ifid_flush = 1; e_idex_bubble = 1;
            end else if (m_flush_left > 0) begin
                e_ifid_flush = 1;
            end else if (lu) begin
                e_pc_hold = 1; e_ifid_hold = 1; e_idex_bubble = 1;
            end
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            m_flush_left = 0; m_busy_run = 0; m_timeout = 0; m_stall = 0;
        end else begin
            if (mem_busy) begin
                m_busy_run++;
                if (m_busy_run >= MT) m_timeout = 1;
            end else begin
                m_busy_run = 0;
                if (branch_taken) m_flush_left = BP - 1;
                else if (m_flush_left > 0) m_flush_left--;
            end
            if (e_pc_hold && m_stall < STALL_MAX) m_stall++;
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        #1;
        model_eval();
        check("PC_hold", 32'(pc_hold), 32'(e_pc_hold));
        check("IF_ID_hold", 32'(ifid_hold), 32'(e_ifid_hold));
        check("IF_ID_flush", 32'(ifid_flush), 32'(e_ifid_flush));
        check("ID_EX_bubble", 32'(idex_bubble), 32'(e_idex_bubble));
        check("ID_EX_hold", 32'(idex_hold), 32'(e_idex_hold));
        check("EX_MEM_hold", 32'(exmem_hold), 32'(e_exmem_hold));
        check("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst_n = 1; src1 = '0; src2 = '0; rd = '0; src1_used = 0; src2_used = 0;
        mem_read = 0; branch_taken = 0; mem_busy = 0;
    endtask

    int burst;

    initial begin
        set_idle();
        rst_n = 0;
        m_flush_left = 0; m_busy_run = 0; m_timeout = 0; m_stall = 0;
        @(negedge clk);
        step();
        step();
        // After two reset edges the counters are known regardless of the model.
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);

        // Load-use on src2, then the bubble in EX clears the hazard.
        set_idle();
        mem_read = 1; rd = 6'd5; src2 = 6'd5; src2_used = 1;
        step();
        set_idle();
        step();
        check("t1_stall", 32'(stall_cycles), 32'd1);
        mem_read = 1; rd = 6'd5; src2 = 6'd5; src2_used = 0;
        step();
        set_idle();

        // Taken branch: three flush cycles, bubble on the first only.
        branch_taken = 1;
        step();
        branch_taken = 0;
        repeat (3) step();

        // Load-use and branch together: branch wins.
        mem_read = 1; rd = 6'd9; src1 = 6'd9; src1_used = 1; branch_taken = 1;
        step();
        set_idle();
        step();  // flush_cnt now 1
        mem_busy = 1;
        repeat (4) step();
        mem_busy = 0;
        step();  // the remaining flush cycle
        check("t4_stall", 32'(stall_cycles), 32'd5);
        step();

        // Timeout: 63 busy cycles do not trip it, the 64th does, and it is sticky.
        mem_busy = 1;
        repeat (63) step();
        check("t5_before", 32'(mem_timeout), 32'd0);
        step();
        mem_busy = 0;
        step();
        check("t5_sticky", 32'(mem_timeout), 32'd1);

        // Saturate the stall counter, enter FLUSH, then reset mid-flush.
        mem_busy = 1;
        repeat (300) step();
        mem_busy = 0;
        check("t6_sat", 32'(stall_cycles), 32'(STALL_MAX));
        branch_taken = 1;
        step();
        branch_taken = 0;
        rst_n = 0;
        step();
        set_idle();
        step();
        check("t6_flush_aborted", 32'(ifid_flush), 32'd0);
        check("t6_stall_cleared", 32'(stall_cycles), 32'd0);
        check("t6_timeout_cleared", 32'(mem_timeout), 32'd0);

        // Random traffic with occasional long memory stalls and resets.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            src1         = AW'($urandom_range(0, 3));
            src2         = AW'($urandom_range(0, 3));
            rd           = AW'($urandom_range(0, 3));
            src1_used    = $urandom_range(0, 1) == 1;
            src2_used    = $urandom_range(0, 1) == 1;
            mem_read     = $urandom_range(0, 1) == 1;
            branch_taken = ($urandom_range(0, 99) < 15);
            if (burst > 0) begin
                mem_busy = 1;
                burst--;
            end else if ($urandom_range(0, 99) < 6) begin
                mem_busy = 1;
                burst = $urandom_range(0, 80);
            end else begin
                mem_busy = 0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
